// File: rtl/mindfocus_game_core.sv
// mindfocus_game_core
// Top-level controller of the MindFocus memory/attention game. Each round
// shows a target button pattern (MOSTRA), hides it during a focus interval
// (FOCO), waits for the player's press (ESPERA) and scores it against the
// target. A game is N_RODADAS rounds long and ends in FIM.
//
// Ports:
//   clock          system clock, rising edge (1 kHz on the board)
//   reset          asynchronous, active-low reset
//   iniciar        start/restart a game (level sampled)
//   voltar         abort to idle from any state (level sampled)
//   botoes[3:0]    player buttons, active-high
//   pronto         high while the game is finished (FIM)
//   acertos[3:0]   number of correct plays, saturating at 15
//   db_igual       combinational: captured play equals current target
//   db_clock       copy of clock
//   db_igualjogada registered result of the last comparison
//   db_tem_jogada  one-cycle pulse on a new press (0000 -> non-zero)
//   db_estado      7-seg (active-low, gfedcba) of the state code
//   db_acertos     7-seg of acertos
//   db_indice0     7-seg of the round number
//   db_indice1     7-seg of the target while showing it, blank otherwise
//   db_indice2     7-seg of the captured play
//   db_indice3     7-seg of elapsed timer seconds, saturated at F
module mindfocus_game_core #(
   parameter int T_MOSTRA  = 5000,
   parameter int T_FOCO    = 5000,
   parameter int T_JOGADA  = 10000,
   parameter int N_RODADAS = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       voltar,
   input  logic [3:0] botoes,
   output logic       pronto,
   output logic [3:0] acertos,
   output logic       db_igual,
   output logic       db_clock,
   output logic       db_igualjogada,
   output logic       db_tem_jogada,
   output logic [6:0] db_estado,
   output logic [6:0] db_acertos,
   output logic [6:0] db_indice0,
   output logic [6:0] db_indice1,
   output logic [6:0] db_indice2,
   output logic [6:0] db_indice3
);

   // State values double as the hex code shown on db_estado.
   typedef enum logic [3:0] {
      INICIAL  = 4'h0,
      PREPARA  = 4'h1,
      MOSTRA   = 4'h2,
      FOCO     = 4'h3,
      ESPERA   = 4'h4,
      REGISTRA = 4'h5,
      COMPARA  = 4'h6,
      PROXIMA  = 4'h7,
      FIM      = 4'hF
   } state_t;

   localparam logic [15:0] MOSTRA_LAST = 16'(T_MOSTRA - 1);
   localparam logic [15:0] FOCO_LAST   = 16'(T_FOCO - 1);
   localparam logic [15:0] JOGADA_LAST = 16'(T_JOGADA - 1);
   localparam logic [3:0]  LAST_ROUND  = 4'(N_RODADAS - 1);
   localparam logic [6:0]  SEG_BLANK   = 7'b1111111;

   state_t      state;
   state_t      next_state;
   logic [15:0] timer;
   logic [3:0]  round;
   logic [3:0]  jogada;
   logic [3:0]  botoes_prev;
   logic [3:0]  target;
   logic        tem_jogada;
   logic [3:0]  seconds;

   // Hex digit to active-low 7-segment pattern, bit order gfedcba.
   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Target ROM indexed by round; rounds beyond the table show no target.
   always_comb begin
      target = 4'b0000;
      case (round)
         4'd0: target = 4'b1000;
         4'd1: target = 4'b0100;
         4'd2: target = 4'b1000;
         4'd3: target = 4'b0001;
         default: target = 4'b0000;
      endcase
   end

   // A press counts only on the transition from all-released to any button,
   // so a held button is seen once and must be released before the next one.
   assign tem_jogada = (botoes != 4'b0000) && (botoes_prev == 4'b0000);

   // Next-state logic. Each timed state leaves on the cycle its timer reaches
   // the last count, which gives exactly T cycles of residence because the
   // timer clears on entry. In ESPERA the press is tested before the timeout
   // so a press arriving on the timeout edge is still accepted. voltar
   // overrides everything except when already idle.
   always_comb begin
      next_state = state;
      case (state)
         INICIAL:  if (iniciar) next_state = PREPARA;
         PREPARA:  next_state = MOSTRA;
         MOSTRA:   if (timer == MOSTRA_LAST) next_state = FOCO;
         FOCO:     if (timer == FOCO_LAST) next_state = ESPERA;
         ESPERA: begin
            if (tem_jogada)                next_state = REGISTRA;
            else if (timer == JOGADA_LAST) next_state = COMPARA;
         end
         REGISTRA: next_state = COMPARA;
         COMPARA:  next_state = PROXIMA;
         PROXIMA:  next_state = (round == LAST_ROUND) ? FIM : MOSTRA;
         FIM:      if (iniciar) next_state = PREPARA;
         default:  next_state = INICIAL;
      endcase
      if (voltar && (state != INICIAL)) next_state = INICIAL;
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= INICIAL;
      else        state <= next_state;
   end

   // Cycle timer: cleared whenever the state changes, otherwise counts up and
   // parks at all-ones so long idle periods never wrap back to zero.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         timer <= 16'd0;
      end else if (next_state != state) begin
         timer <= 16'd0;
      end else if (timer != 16'hFFFF) begin
         timer <= timer + 16'd1;
      end
   end

   // Previous button sample, tracked in every state so buttons held through
   // FOCO cannot register as a fresh press when ESPERA begins.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) botoes_prev <= 4'b0000;
      else        botoes_prev <= botoes;
   end

   // Round datapath. Updates are qualified by next_state so an abort
   // (voltar) on the same edge suppresses them.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         round          <= 4'd0;
         jogada         <= 4'b0000;
         acertos        <= 4'd0;
         db_igualjogada <= 1'b0;
      end else begin
         case (state)
            PREPARA: begin
               round          <= 4'd0;
               jogada         <= 4'b0000;
               acertos        <= 4'd0;
               db_igualjogada <= 1'b0;
            end
            ESPERA: begin
               if (next_state == COMPARA) jogada <= 4'b0000;
            end
            REGISTRA: begin
               if (next_state == COMPARA) jogada <= botoes;
            end
            COMPARA: begin
               if (next_state == PROXIMA) begin
                  db_igualjogada <= (jogada == target);
                  if ((jogada == target) && (acertos != 4'd15))
                     acertos <= acertos + 4'd1;
               end
            end
            PROXIMA: begin
               if (next_state == MOSTRA) round <= round + 4'd1;
            end
            default: ;
         endcase
      end
   end

   // Elapsed whole seconds of the current state at 1 kHz, capped at F.
   always_comb begin
      seconds = 4'd15;
      if (timer < 16'd15000) seconds = 4'(timer / 16'd1000);
   end

   // Outputs decoded from registered state and datapath.
   always_comb begin
      pronto        = (state == FIM);
      db_igual      = (jogada == target);
      db_clock      = clock;
      db_tem_jogada = tem_jogada;
      db_estado     = hex7(state);
      db_acertos    = hex7(acertos);
      db_indice0    = hex7(round);
      db_indice1    = (state == MOSTRA) ? hex7(target) : SEG_BLANK;
      db_indice2    = hex7(jogada);
      db_indice3    = hex7(seconds);
   end

endmodule

// File: tb/tb_mindfocus_game_core.sv
// tb_mindfocus_game_core
// Plays randomized games against mindfocus_game_core with shortened timers.
// Expected behaviour comes from the game rules: state codes at the cycle
// offsets implied by the timer lengths, score counted from presses that
// match the round's target, and 7-seg patterns from the digit table.
module tb_mindfocus_game_core;

   localparam int TM = 800;
   localparam int TF = 300;
   localparam int TJ = 2100;
   localparam int NR = 4;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic       voltar;
   logic [3:0] botoes;
   logic       pronto;
   logic [3:0] acertos;
   logic       db_igual;
   logic       db_clock;
   logic       db_igualjogada;
   logic       db_tem_jogada;
   logic [6:0] db_estado;
   logic [6:0] db_acertos;
   logic [6:0] db_indice0;
   logic [6:0] db_indice1;
   logic [6:0] db_indice2;
   logic [6:0] db_indice3;

   int checks   = 0;
   int failures = 0;
   int expScore = 0;

   mindfocus_game_core #(
      .T_MOSTRA (TM),
      .T_FOCO   (TF),
      .T_JOGADA (TJ),
      .N_RODADAS(NR)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .iniciar       (iniciar),
      .voltar        (voltar),
      .botoes        (botoes),
      .pronto        (pronto),
      .acertos       (acertos),
      .db_igual      (db_igual),
      .db_clock      (db_clock),
      .db_igualjogada(db_igualjogada),
      .db_tem_jogada (db_tem_jogada),
      .db_estado     (db_estado),
      .db_acertos    (db_acertos),
      .db_indice0    (db_indice0),
      .db_indice1    (db_indice1),
      .db_indice2    (db_indice2),
      .db_indice3    (db_indice3)
   );

   // Free-running clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Guard against a stuck run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Digit table for the active-low gfedcba display.
   function automatic logic [6:0] segOf(input int v);
      case (v)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         10: return 7'b0001000;
         11: return 7'b0000011;
         12: return 7'b1000110;
         13: return 7'b0100001;
         14: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   // Target pattern shown in each round.
   function automatic logic [3:0] targetOf(input int r);
      case (r)
         0: return 4'b1000;
         1: return 4'b0100;
         2: return 4'b1000;
         3: return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic int secondsOf(input int cycles);
      return (cycles / 1000 > 15) ? 15 : cycles / 1000;
   endfunction

   // Single comparison point: counts and reports any difference.
   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic ini, input logic vol, input logic [3:0] bot);
      iniciar = ini;
      voltar  = vol;
      botoes  = bot;
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // One round, entered at the falling edge just after MOSTRA begins and
   // left at the falling edge just after PROXIMA begins (or INICIAL on abort).
   task automatic runRound(input int r, input bit doAbort, output bit aborted);
      int d;
      int p;
      bit timeout;
      aborted = 1'b0;
      checkOutput("mostra_entry", 16'(db_estado), 16'(segOf(2)));
      checkOutput("indice0_round", 16'(db_indice0), 16'(segOf(r)));
      checkOutput("indice1_target", 16'(db_indice1), 16'(segOf(int'(targetOf(r)))));
      tick(TM - 1);
      checkOutput("mostra_last", 16'(db_estado), 16'(segOf(2)));
      checkOutput("mostra_secs", 16'(db_indice3), 16'(segOf(secondsOf(TM - 1))));
      tick(1);
      checkOutput("foco_entry", 16'(db_estado), 16'(segOf(3)));
      checkOutput("foco_blank", 16'(db_indice1), 16'h7F);
      if (doAbort) begin
         d = $urandom_range(0, TF - 2);
         tick(d);
         applyStimulus(1'b0, 1'b1, 4'b0000);
         tick(1);
         applyStimulus(1'b0, 1'b0, 4'b0000);
         checkOutput("abort_state", 16'(db_estado), 16'(segOf(0)));
         checkOutput("abort_pronto", 16'(pronto), 16'd0);
         checkOutput("abort_acertos", 16'(acertos), 16'(expScore));
         aborted = 1'b1;
         return;
      end
      // A press during FOCO is ignored; buttons are released before ESPERA.
      tick(TF / 2);
      applyStimulus(1'b0, 1'b0, 4'($urandom_range(1, 15)));
      tick(3);
      checkOutput("foco_ignores_press", 16'(db_estado), 16'(segOf(3)));
      applyStimulus(1'b0, 1'b0, 4'b0000);
      tick(TF - TF / 2 - 4);
      checkOutput("foco_last", 16'(db_estado), 16'(segOf(3)));
      tick(1);
      checkOutput("espera_entry", 16'(db_estado), 16'(segOf(4)));
      timeout = ($urandom_range(0, 3) == 0);
      if (!timeout) begin
         d = ($urandom_range(0, 3) == 0) ? TJ - 1 : int'($urandom_range(0, TJ - 1));
         p = ($urandom_range(0, 1) == 1) ? int'(targetOf(r)) : int'($urandom_range(1, 15));
         tick(d);
         checkOutput("espera_wait", 16'(db_estado), 16'(segOf(4)));
         checkOutput("espera_secs", 16'(db_indice3), 16'(segOf(secondsOf(d))));
         applyStimulus(1'b0, 1'b0, 4'(p));
         #1;
         checkOutput("tem_jogada_pulse", 16'(db_tem_jogada), 16'd1);
         tick(1);
         checkOutput("registra", 16'(db_estado), 16'(segOf(5)));
         checkOutput("held_no_retrigger", 16'(db_tem_jogada), 16'd0);
         tick(1);
         checkOutput("compara", 16'(db_estado), 16'(segOf(6)));
         checkOutput("indice2_jogada", 16'(db_indice2), 16'(segOf(p)));
         checkOutput("db_igual", 16'(db_igual), 16'(p == int'(targetOf(r))));
         if ((p == int'(targetOf(r))) && (expScore < 15)) expScore++;
         tick(1);
         checkOutput("proxima", 16'(db_estado), 16'(segOf(7)));
         checkOutput("igualjogada", 16'(db_igualjogada), 16'(p == int'(targetOf(r))));
         checkOutput("held_still_no_pulse", 16'(db_tem_jogada), 16'd0);
         applyStimulus(1'b0, 1'b0, 4'b0000);
      end else begin
         tick(TJ - 1);
         checkOutput("espera_last", 16'(db_estado), 16'(segOf(4)));
         checkOutput("espera_last_secs", 16'(db_indice3), 16'(segOf(secondsOf(TJ - 1))));
         tick(1);
         checkOutput("timeout_compara", 16'(db_estado), 16'(segOf(6)));
         checkOutput("timeout_jogada", 16'(db_indice2), 16'(segOf(0)));
         checkOutput("timeout_igual", 16'(db_igual), 16'd0);
         tick(1);
         checkOutput("timeout_proxima", 16'(db_estado), 16'(segOf(7)));
         checkOutput("timeout_igualjogada", 16'(db_igualjogada), 16'd0);
      end
      checkOutput("acertos_count", 16'(acertos), 16'(expScore));
      checkOutput("db_acertos", 16'(db_acertos), 16'(segOf(expScore)));
   endtask

   // Starts a game from INICIAL or FIM and plays all rounds unless aborted.
   task automatic runGame(input bit doAbort, input int abortRound);
      bit aborted;
      applyStimulus(1'b1, 1'b0, 4'b0000);
      tick(1);
      applyStimulus(1'b0, 1'b0, 4'b0000);
      checkOutput("prepara", 16'(db_estado), 16'(segOf(1)));
      checkOutput("prepara_pronto", 16'(pronto), 16'd0);
      tick(1);
      expScore = 0;
      checkOutput("start_acertos", 16'(acertos), 16'd0);
      checkOutput("start_igualjogada", 16'(db_igualjogada), 16'd0);
      checkOutput("start_jogada", 16'(db_indice2), 16'(segOf(0)));
      for (int r = 0; r < NR; r++) begin
         runRound(r, doAbort && (r == abortRound), aborted);
         if (aborted) return;
         tick(1);
         if (r == NR - 1) begin
            checkOutput("fim", 16'(db_estado), 16'(segOf(15)));
            checkOutput("fim_pronto", 16'(pronto), 16'd1);
            checkOutput("fim_acertos", 16'(acertos), 16'(expScore));
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 4'b0000);
      tick(2);
      checkOutput("rst_estado", 16'(db_estado), 16'(segOf(0)));
      checkOutput("rst_acertos", 16'(acertos), 16'd0);
      checkOutput("rst_pronto", 16'(pronto), 16'd0);
      checkOutput("rst_indice1", 16'(db_indice1), 16'h7F);
      checkOutput("rst_indice0", 16'(db_indice0), 16'(segOf(0)));
      checkOutput("rst_indice2", 16'(db_indice2), 16'(segOf(0)));
      checkOutput("rst_igualjogada", 16'(db_igualjogada), 16'd0);
      checkOutput("rst_tem_jogada", 16'(db_tem_jogada), 16'd0);
      checkOutput("db_clock_low", 16'(db_clock), 16'd0);
      reset = 1'b1;
      tick(3);
      checkOutput("idle_holds", 16'(db_estado), 16'(segOf(0)));

      $display("[TB] game 1");
      runGame(1'b0, 0);
      tick(15000);
      checkOutput("fim_secs_saturate", 16'(db_indice3), 16'(segOf(15)));
      checkOutput("fim_pronto_held", 16'(pronto), 16'd1);

      $display("[TB] game 2 with abort during FOCO");
      runGame(1'b1, int'($urandom_range(0, NR - 2)));
      tick(4);
      checkOutput("idle_after_abort", 16'(db_estado), 16'(segOf(0)));

      $display("[TB] game 3");
      runGame(1'b0, 0);
      applyStimulus(1'b1, 1'b1, 4'b0000);
      tick(1);
      applyStimulus(1'b0, 1'b0, 4'b0000);
      checkOutput("voltar_beats_iniciar", 16'(db_estado), 16'(segOf(0)));
      checkOutput("voltar_pronto", 16'(pronto), 16'd0);
      checkOutput("voltar_acertos", 16'(acertos), 16'(expScore));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mindfocus_game_core.md
# mindfocus_game_core

Top-level controller of the MindFocus memory/attention game. Each round shows a target button pattern, hides it for a focus interval, then waits for the player's press and scores it. The block holds the FSM, timers, round counter, target ROM, play capture and score counter, plus the 7-segment debug outputs. It sits directly under the board top level and is clocked at 1 kHz.

## Interface
- T_MOSTRA, 5000: cycles the target is shown (5 s at 1 kHz).
- T_FOCO, 5000: cycles of the hidden focus interval.
- T_JOGADA, 10000: play-wait timeout in cycles.
- N_RODADAS, 4: rounds per game (max 15).
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start/restart game, level sampled.
- voltar  in  1  abort to idle, level sampled.
- botoes  in  4  player buttons, active-high.
- pronto  out  1  game finished.
- acertos  out  4  correct-play count.
- db_igual  out  1  combinational: captured play == current target.
- db_clock  out  1  copy of clock.
- db_igualjogada  out  1  registered result of the last comparison.
- db_tem_jogada  out  1  one-cycle pulse on a new press.
- db_estado, db_acertos, db_indice0..3  out  7 each  7-segment, active-low, bit order gfedcba.

## Operation
- The target ROM is indexed by round: 0:1000, 1:0100, 2:1000, 3:0001; any other index gives 0000.
- Press detection uses a registered botoes_prev. tem_jogada = (botoes != 0) && (botoes_prev == 0), so a held button counts once and the buttons must return to 0000 before the next press counts.
- State codes shown on db_estado in hex:
  - INICIAL (0): idle. iniciar goes to PREPARA.
  - PREPARA (1): one cycle. Clears acertos, round, jogada, timer and db_igualjogada. Goes to MOSTRA.
  - MOSTRA (2): stays exactly T_MOSTRA cycles, then goes to FOCO.
  - FOCO (3): stays exactly T_FOCO cycles. Presses are ignored, but botoes_prev still tracks the buttons. Then goes to ESPERA.
  - ESPERA (4): tem_jogada goes to REGISTRA. If T_JOGADA cycles pass first, jogada := 0000 and the FSM goes to COMPARA.
  - REGISTRA (5): jogada := botoes. Goes to COMPARA.
  - COMPARA (6): db_igualjogada := (jogada == target). If equal, acertos += 1, saturating at 15. Goes to PROXIMA.
  - PROXIMA (7): if round == N_RODADAS-1, go to FIM. Otherwise round += 1 and go to MOSTRA.
  - FIM (F): pronto = 1. iniciar goes to PREPARA.
- voltar in any state other than INICIAL goes to INICIAL on the next edge. acertos is retained; pronto drops.
- Multi-bit presses are captured as-is and score as misses.
- Debug display:
  - db_indice0 = round in hex.
  - db_indice1 = target in hex during MOSTRA, blank (1111111) otherwise.
  - db_indice2 = jogada in hex.
  - db_indice3 = elapsed timer seconds (timer/1000, saturated at F) in hex.
  - db_acertos = acertos in hex.
- Hex segment patterns, active-low, gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

## Timing
- Reset (reset=0, asynchronous) sets:
  - state INICIAL, round 0, jogada 0000, timer 0, botoes_prev 0000.
  - acertos 0, pronto 0, db_igualjogada 0, db_tem_jogada 0.
  - db_estado shows 0.
- All state changes occur on the rising edge. Outputs are Moore-registered except db_igual, db_tem_jogada and db_clock.
- The timer clears on every state entry.
- If iniciar is high at edge k in INICIAL, the FSM is in PREPARA at k+1, MOSTRA at k+2, FOCO at k+2+T_MOSTRA and ESPERA at k+2+T_MOSTRA+T_FOCO.
- From a press edge in ESPERA, REGISTRA follows at +1, COMPARA at +2 (acertos updated at +3) and PROXIMA at +3.
- Priority when events coincide:
  - voltar has priority over all other transitions.
  - iniciar and voltar together in FIM: voltar wins.
  - A press on the same edge as the timeout is accepted.

## Test plan
- Reset pulse: reset=0 for one cycle then 1 -> acertos=0, pronto=0, db_estado=1000000 (state 0), db_indice1 blank.
- Start then wait: iniciar for one cycle -> state 1 for one cycle, 2 for 5000 cycles, 3 for 5000 cycles, then 4. db_indice1 shows 8 only during state 2.
- Round 0 correct: press 1000 about 7 cycles into ESPERA and hold 10000 cycles -> db_tem_jogada pulses once, acertos=1, db_igualjogada=1. The held button does not re-trigger.
- Rounds 1 and 2, pressing 1000 each time after a release plus about 5000 cycles:
  - round 1 (target 0100) is a miss, acertos stays 1, db_igualjogada=0.
  - round 2 (target 1000) scores, acertos=2.
- Round 3 timeout: no press for 10000 cycles in ESPERA -> miss, FIM, pronto=1, acertos=2. Then iniciar -> PREPARA, acertos=0.
- Abort: voltar during FOCO -> INICIAL on the next edge, pronto=0, acertos retained.
